// File: rtl/hs_pkg.sv
// Shared constants and FSM state encoding for the high-score table controller.
package hs_pkg;

  localparam int NUM_GAMES = 8;
  localparam int GID_W     = 3;
  localparam int PID_W     = 3;
  localparam int SCORE_W   = 7;
  localparam int ENTRY_W   = PID_W + SCORE_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    UPD_RD,
    UPD_CMP,
    DSP_RD,
    DSP_OUT
  } hsState_t;

endpackage

// File: rtl/hs_ram.sv
// Single-port high-score storage: synchronous write, one-cycle registered read.
// Read data only changes on an explicit read, so it stays stable while the
// controller works through a transaction.
module hs_ram
  import hs_pkg::*;
#(
  parameter int DEPTH = hs_pkg::NUM_GAMES,
  parameter int AW    = hs_pkg::GID_W,
  parameter int DW    = hs_pkg::ENTRY_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wrData,
  output logic [DW-1:0] rdData
);

  logic [DW-1:0] mem [DEPTH];

  // Write has priority; otherwise a read request loads the output register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wrData;
    end else if (re) begin
      rdData <= mem[addr];
    end
  end

endmodule

// File: rtl/highscore_ctrl.sv
// High-score table controller: captures submit/lookup/clear requests,
// arbitrates them onto hs_ram and performs read-compare-write updates.
//
// state   | meaning
// IDLE    | arbitrate pending requests (clear > update > display)
// CLEAR   | zero one entry per cycle via clrCnt
// UPD_RD  | wait for stored entry of the submitted game
// UPD_CMP | compare scores, write on a strict improvement, ack
// DSP_RD  | wait for stored entry of the requested game
// DSP_OUT | register record holder/score, ack
module highscore_ctrl
  import hs_pkg::*;
#(
  parameter int NUM_GAMES = hs_pkg::NUM_GAMES,
  parameter int GID_W     = hs_pkg::GID_W,
  parameter int PID_W     = hs_pkg::PID_W,
  parameter int SCORE_W   = hs_pkg::SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               updReq,
  input  logic [PID_W-1:0]   updPID,
  input  logic [GID_W-1:0]   updGID,
  input  logic [SCORE_W-1:0] updScore,
  output logic               updAck,
  output logic               newRecord,
  input  logic               dispReq,
  input  logic [GID_W-1:0]   dispGID,
  output logic               dispAck,
  output logic [PID_W-1:0]   dispPID,
  output logic [SCORE_W-1:0] dispScore,
  input  logic               clrReq,
  output logic               busy
);

  localparam int EntryW = PID_W + SCORE_W;
  localparam logic [GID_W-1:0] LastAddr = GID_W'(NUM_GAMES - 1);

  hsState_t state, stateNext;

  logic               updPend, dispPend, clrPend;
  logic [PID_W-1:0]   updPIDCap;
  logic [GID_W-1:0]   updGIDCap;
  logic [SCORE_W-1:0] updScoreCap;
  logic [GID_W-1:0]   dispGIDCap;

  // Working copy of the granted request, so new pulses cannot disturb it.
  logic [PID_W-1:0]   workPID;
  logic [GID_W-1:0]   workGID;
  logic [SCORE_W-1:0] workScore;

  logic [GID_W-1:0]   clrCnt;
  logic               grantClr, grantUpd, grantDsp;
  logic               isRecord;

  logic               ramWe, ramRe;
  logic [GID_W-1:0]   ramAddr;
  logic [EntryW-1:0]  ramWrData, ramRdData;

  hs_ram #(
    .DEPTH (NUM_GAMES),
    .AW    (GID_W),
    .DW    (EntryW)
  ) uRam (
    .clk    (clk),
    .we     (ramWe),
    .re     (ramRe),
    .addr   (ramAddr),
    .wrData (ramWrData),
    .rdData (ramRdData)
  );

  assign isRecord = workScore > ramRdData[SCORE_W-1:0];

  // Next-state, arbitration and RAM port control; writes are blocked while rst is low.
  always_comb begin
    stateNext = state;
    grantClr  = 1'b0;
    grantUpd  = 1'b0;
    grantDsp  = 1'b0;
    ramWe     = 1'b0;
    ramRe     = 1'b0;
    ramAddr   = workGID;
    ramWrData = {workPID, workScore};
    case (state)
      IDLE: begin
        if (clrPend) begin
          grantClr  = 1'b1;
          stateNext = CLEAR;
        end else if (updPend) begin
          grantUpd  = 1'b1;
          ramRe     = 1'b1;
          ramAddr   = updGIDCap;
          stateNext = UPD_RD;
        end else if (dispPend) begin
          grantDsp  = 1'b1;
          ramRe     = 1'b1;
          ramAddr   = dispGIDCap;
          stateNext = DSP_RD;
        end
      end
      CLEAR: begin
        ramWe     = rst;
        ramAddr   = clrCnt;
        ramWrData = '0;
        if (clrCnt == LastAddr) stateNext = IDLE;
      end
      UPD_RD:  stateNext = UPD_CMP;
      UPD_CMP: begin
        ramWe     = isRecord & rst;
        stateNext = IDLE;
      end
      DSP_RD:  stateNext = DSP_OUT;
      DSP_OUT: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register and clear address counter; reset starts an auto-clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= CLEAR;
      clrCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == CLEAR) clrCnt <= clrCnt + 1'b1;
      else                clrCnt <= '0;
    end
  end

  // Pending flags and per-source capture; a new pulse overwrites older data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      updPend     <= 1'b0;
      dispPend    <= 1'b0;
      clrPend     <= 1'b0;
      updPIDCap   <= '0;
      updGIDCap   <= '0;
      updScoreCap <= '0;
      dispGIDCap  <= '0;
    end else begin
      updPend  <= updReq  | (updPend  & ~grantUpd);
      dispPend <= dispReq | (dispPend & ~grantDsp);
      clrPend  <= clrReq  | (clrPend  & ~grantClr);
      if (updReq) begin
        updPIDCap   <= updPID;
        updGIDCap   <= updGID;
        updScoreCap <= updScore;
      end
      if (dispReq) dispGIDCap <= dispGID;
    end
  end

  // Latch the granted request into the working registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      workPID   <= '0;
      workGID   <= '0;
      workScore <= '0;
    end else if (grantUpd) begin
      workPID   <= updPIDCap;
      workGID   <= updGIDCap;
      workScore <= updScoreCap;
    end else if (grantDsp) begin
      workGID   <= dispGIDCap;
    end
  end

  // Registered outputs: ack pulses, display data and busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      updAck    <= 1'b0;
      newRecord <= 1'b0;
      dispAck   <= 1'b0;
      dispPID   <= '0;
      dispScore <= '0;
      busy      <= 1'b0;
    end else begin
      updAck    <= (state == UPD_CMP);
      newRecord <= (state == UPD_CMP) & isRecord;
      dispAck   <= (state == DSP_OUT);
      if (state == DSP_OUT) begin
        dispPID   <= ramRdData[EntryW-1:SCORE_W];
        dispScore <= ramRdData[SCORE_W-1:0];
      end
      busy <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_highscore_ctrl.sv
// Self-checking bench for highscore_ctrl with a table-level reference model.
module tb_highscore_ctrl;

  localparam int NG      = 8;
  localparam int GID_W   = 3;
  localparam int PID_W   = 3;
  localparam int SCORE_W = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               updReq;
  logic [PID_W-1:0]   updPID;
  logic [GID_W-1:0]   updGID;
  logic [SCORE_W-1:0] updScore;
  logic               updAck;
  logic               newRecord;
  logic               dispReq;
  logic [GID_W-1:0]   dispGID;
  logic               dispAck;
  logic [PID_W-1:0]   dispPID;
  logic [SCORE_W-1:0] dispScore;
  logic               clrReq;
  logic               busy;

  int nChecks = 0;
  int nErr    = 0;
  int refPID   [NG];
  int refScore [NG];

  always #5 clk = ~clk;

  highscore_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .updReq    (updReq),
    .updPID    (updPID),
    .updGID    (updGID),
    .updScore  (updScore),
    .updAck    (updAck),
    .newRecord (newRecord),
    .dispReq   (dispReq),
    .dispGID   (dispGID),
    .dispAck   (dispAck),
    .dispPID   (dispPID),
    .dispScore (dispScore),
    .clrReq    (clrReq),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NG; i++) begin
      refPID[i]   = 0;
      refScore[i] = 0;
    end
  endtask

  task automatic pulseUpd(input int pid, input int gid, input int score);
    @(negedge clk);
    updReq   = 1'b1;
    updPID   = PID_W'(pid);
    updGID   = GID_W'(gid);
    updScore = SCORE_W'(score);
    @(negedge clk);
    updReq   = 1'b0;
  endtask

  task automatic pulseDisp(input int gid);
    @(negedge clk);
    dispReq = 1'b1;
    dispGID = GID_W'(gid);
    @(negedge clk);
    dispReq = 1'b0;
  endtask

  task automatic waitUpd(input string tag, input int pid, input int gid, input int score);
    bit got = 1'b0;
    bit expNr;
    expNr = (score > refScore[gid]);
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (updAck === 1'b1) got = 1'b1;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    if (got) check({tag, "_newRecord"}, 32'(newRecord), 32'(expNr));
    if (expNr) begin
      refPID[gid]   = pid;
      refScore[gid] = score;
    end
  endtask

  task automatic waitDisp(input string tag, input int gid);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (dispAck === 1'b1) got = 1'b1;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    check({tag, "_pid"}, 32'(dispPID), 32'(refPID[gid]));
    check({tag, "_score"}, 32'(dispScore), 32'(refScore[gid]));
  endtask

  initial begin
    int updAt, dispAt, nAcks, nrSeen, scoreSeen, pidSeen;
    int pid, gid, score;

    rst = 1'b0; updReq = 1'b0; dispReq = 1'b0; clrReq = 1'b0;
    updPID = '0; updGID = '0; updScore = '0; dispGID = '0;
    clearModel();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_updAck", 32'(updAck), 32'd0);
    check("rst_newRecord", 32'(newRecord), 32'd0);
    check("rst_dispAck", 32'(dispAck), 32'd0);
    check("rst_dispPID", 32'(dispPID), 32'd0);
    check("rst_dispScore", 32'(dispScore), 32'd0);

    // Auto-clear after reset release
    @(negedge clk);
    rst = 1'b1;
    repeat (NG - 1) @(posedge clk);
    #1;
    check("clear_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("clear_done", 32'(busy), 32'd0);

    pulseDisp(5);
    waitDisp("rd_after_reset", 5);

    // Directed record sequence on GID 3
    pulseUpd(2, 3, 17);
    waitUpd("upd_first", 2, 3, 17);
    pulseDisp(3);
    waitDisp("rd_first", 3);
    pulseUpd(4, 3, 17);
    waitUpd("upd_equal", 4, 3, 17);
    pulseDisp(3);
    waitDisp("rd_equal", 3);
    pulseUpd(4, 3, 18);
    waitUpd("upd_better", 4, 3, 18);
    pulseDisp(3);
    waitDisp("rd_better", 3);

    // Two update pulses while busy: latest wins, one ack
    @(negedge clk); dispReq = 1'b1; dispGID = 3'd7;
    @(negedge clk); dispReq = 1'b0;
    @(negedge clk); updReq = 1'b1; updPID = 3'd1; updGID = 3'd0; updScore = 7'd5;
    @(negedge clk); updPID = 3'd6; updScore = 7'd30;
    @(negedge clk); updReq = 1'b0;
    nAcks = 0; nrSeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (updAck === 1'b1) begin
        nAcks++;
        nrSeen = int'(newRecord);
      end
    end
    check("dbl_ack_count", 32'(nAcks), 32'd1);
    check("dbl_newRecord", 32'(nrSeen), 32'd1);
    refPID[0] = 6; refScore[0] = 30;
    pulseDisp(0);
    waitDisp("dbl_rd", 0);

    // Simultaneous update and display of GID 1
    @(negedge clk);
    updReq = 1'b1; updPID = 3'd3; updGID = 3'd1; updScore = 7'd9;
    dispReq = 1'b1; dispGID = 3'd1;
    @(negedge clk); updReq = 1'b0; dispReq = 1'b0;
    updAt = -1; dispAt = -1; scoreSeen = -1; pidSeen = -1; nrSeen = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (updAck === 1'b1) begin updAt = i; nrSeen = int'(newRecord); end
      if (dispAck === 1'b1) begin dispAt = i; scoreSeen = int'(dispScore); pidSeen = int'(dispPID); end
    end
    check("sim_upd_seen", 32'(updAt >= 0), 32'd1);
    check("sim_order", 32'(dispAt > updAt), 32'd1);
    check("sim_newRecord", 32'(nrSeen), 32'(9 > refScore[1]));
    if (9 > refScore[1]) begin refPID[1] = 3; refScore[1] = 9; end
    check("sim_disp_score", 32'(scoreSeen), 32'(refScore[1]));
    check("sim_disp_pid", 32'(pidSeen), 32'(refPID[1]));

    // Clear request during an update, display queued behind it
    @(negedge clk);
    updReq = 1'b1; updPID = 3'd5; updGID = 3'd2; updScore = 7'd50;
    @(negedge clk);
    updReq = 1'b0; clrReq = 1'b1; dispReq = 1'b1; dispGID = 3'd2;
    @(negedge clk); clrReq = 1'b0; dispReq = 1'b0;
    updAt = -1; dispAt = -1; scoreSeen = -1; nrSeen = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (updAck === 1'b1) begin updAt = i; nrSeen = int'(newRecord); end
      if (dispAck === 1'b1) begin dispAt = i; scoreSeen = int'(dispScore); end
    end
    check("clr_upd_seen", 32'(updAt >= 0), 32'd1);
    check("clr_upd_newRecord", 32'(nrSeen), 32'(50 > refScore[2]));
    check("clr_order", 32'(dispAt > updAt), 32'd1);
    check("clr_disp_score", 32'(scoreSeen), 32'd0);
    clearModel();
    for (int g = 0; g < NG; g++) begin
      pulseDisp(g);
      waitDisp("clr_sweep", g);
    end

    // Randomized submissions and lookups
    for (int n = 0; n < 24; n++) begin
      pid   = int'($urandom_range(0, 7));
      gid   = int'($urandom_range(0, 7));
      score = int'($urandom_range(0, 127));
      pulseUpd(pid, gid, score);
      waitUpd("rnd_upd", pid, gid, score);
      if ($urandom_range(0, 1) == 1) begin
        gid = int'($urandom_range(0, 7));
        pulseDisp(gid);
        waitDisp("rnd_rd", gid);
      end
    end
    for (int g = 0; g < NG; g++) begin
      pulseDisp(g);
      waitDisp("rnd_sweep", g);
    end

    // Reset while the update is in UPD_RD: no ack, table cleared
    @(negedge clk);
    updReq = 1'b1; updPID = 3'd7; updGID = 3'd4; updScore = 7'd127;
    @(negedge clk); updReq = 1'b0;
    @(negedge clk); rst = 1'b0;
    nAcks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (updAck === 1'b1) nAcks++;
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (updAck === 1'b1) nAcks++;
    end
    check("rstmid_no_ack", 32'(nAcks), 32'd0);
    clearModel();
    for (int g = 0; g < NG; g++) begin
      pulseDisp(g);
      waitDisp("rstmid_sweep", g);
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
